// File: rtl/sysahb_timer_pkg.sv
// Shared constants for the AHB-Lite timer: register offsets, CTRL bit positions,
// AHB encodings and the bus state machine states.
package sysahb_timer_pkg;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_LOAD   = 3'd1;
    localparam logic [2:0] OFF_VALUE  = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_PRESC  = 3'd4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IE     = 1;
    localparam int CTRL_RELOAD = 2;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } bus_state_e;

    // Word-sized only, offsets up to PRESC, and VALUE is read-only.
    function automatic logic xfer_legal(input logic [2:0] off, input logic wr,
                                        input logic [2:0] sz);
        return (sz == HSIZE_WORD) && (off <= OFF_PRESC) && !(wr && (off == OFF_VALUE));
    endfunction

endpackage

// File: rtl/sysahb_timer_core.sv
// Prescaler plus 32-bit down-counter; reports a one-cycle underflow pulse
// when a prescaler tick finds the counter already at zero.
module timer_core #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  en,
    input  logic                  reload,
    input  logic [PRESCALE_W-1:0] presc,
    input  logic [31:0]           load,
    input  logic                  load_strobe,
    output logic [31:0]           value,
    output logic                  underflow
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [31:0]           value_q, value_d;
    logic                  tick;

    assign tick      = en && (cnt_q == presc);
    // A LOAD write swallows a coincident tick, so it cannot underflow either.
    assign underflow = tick && (value_q == 32'd0) && !load_strobe;
    assign value     = value_q;

    always_comb begin
        cnt_d   = cnt_q;
        value_d = value_q;
        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (tick) begin
            if (value_q != 32'd0) begin
                value_d = value_q - 32'd1;
            end else if (reload) begin
                value_d = load;
            end
        end
        if (load_strobe) begin
            value_d = load;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q   <= '0;
            value_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/sysahb_timer.sv
// AHB-Lite slave timer: bus state machine and register file, with the
// counting datapath in timer_core.
module sysahb_timer
    import sysahb_timer_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hreadyin,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp,
    output logic        irq
);

    bus_state_e            state_q, state_d;
    logic [2:0]            addr_q, addr_d;
    logic                  write_q, write_d;
    logic [2:0]            size_q, size_d;
    logic [2:0]            ctrl_q, ctrl_d;
    logic [31:0]           load_q, load_d;
    logic                  if_q, if_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  irq_q, irq_d;

    logic        accept, legal, wr_en, load_strobe, underflow;
    logic [31:0] value;
    logic        unused_bits;

    assign accept      = hsel && hreadyin && htrans[1];
    assign legal       = xfer_legal(haddr[4:2], hwrite, hsize);
    assign wr_en       = (state_q == ST_DATA) && write_q;
    assign load_strobe = wr_en && (addr_q == OFF_LOAD);
    assign unused_bits = ^{haddr[31:5], haddr[1:0], htrans[0], size_q};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (accept) begin
            state_d = legal ? ST_DATA : ST_ERR1;
            addr_d  = haddr[4:2];
            write_d = hwrite;
            size_d  = hsize;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Bus writes are applied after the core's side effects so they take priority,
    // except that a fresh underflow always sets IF.
    always_comb begin
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        if_d    = if_q;
        presc_d = presc_q;
        if (underflow && !ctrl_q[CTRL_RELOAD]) begin
            ctrl_d[CTRL_EN] = 1'b0;
        end
        if (wr_en) begin
            case (addr_q)
                OFF_CTRL:   ctrl_d  = hwdata[2:0];
                OFF_LOAD:   load_d  = hwdata;
                OFF_STATUS: if (hwdata[0]) if_d = 1'b0;
                OFF_PRESC:  presc_d = hwdata[PRESCALE_W-1:0];
                default:    ;
            endcase
        end
        if (underflow) begin
            if_d = 1'b1;
        end
        irq_d = if_q && ctrl_q[CTRL_IE];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            ctrl_q  <= '0;
            load_q  <= '0;
            if_q    <= 1'b0;
            presc_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            if_q    <= if_d;
            presc_q <= presc_d;
            irq_q   <= irq_d;
        end
    end

    timer_core #(
        .PRESCALE_W(PRESCALE_W)
    ) u_core (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .en         (ctrl_q[CTRL_EN]),
        .reload     (ctrl_q[CTRL_RELOAD]),
        .presc      (presc_q),
        .load       (load_d),
        .load_strobe(load_strobe),
        .value      (value),
        .underflow  (underflow)
    );

    always_comb begin
        hrdata = 32'd0;
        if ((state_q == ST_DATA) && !write_q) begin
            case (addr_q)
                OFF_CTRL:   hrdata = {29'd0, ctrl_q};
                OFF_LOAD:   hrdata = load_q;
                OFF_VALUE:  hrdata = value;
                OFF_STATUS: hrdata = {31'd0, if_q};
                OFF_PRESC:  hrdata = 32'(presc_q);
                default:    hrdata = 32'd0;
            endcase
        end
    end

    assign hready = (state_q != ST_ERR1);
    assign hresp  = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign irq    = irq_q;

endmodule

// File: tb/tb_sysahb_timer.sv
// Directed bench for sysahb_timer: a register-access vector table followed by
// hand-timed sequences for counting, interrupts, prescaling, collisions and reset.
module tb_sysahb_timer;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b010;
    logic [31:0] hwdata = '0;
    logic [31:0] hrdata;
    logic        hready_w;
    logic        hresp;
    logic        irq;

    int checks = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    sysahb_timer #(.PRESCALE_W(16)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .hsel    (hsel),
        .haddr   (haddr),
        .htrans  (htrans),
        .hwrite  (hwrite),
        .hsize   (hsize),
        .hwdata  (hwdata),
        .hreadyin(hready_w),
        .hrdata  (hrdata),
        .hready  (hready_w),
        .hresp   (hresp),
        .irq     (irq)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        act;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } op_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee);
        vec_t v;
        v.wr = wr; v.addr = a; v.size = sz; v.wdata = wd; v.exp_rd = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    task automatic set_addr(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
    endtask

    task automatic clr_addr();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hsize = 3'b010;
    endtask

    // Single transfer: address cycle, then samples the two cycles that follow.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic r0, output logic e0, output logic r1, output logic e1);
        @(negedge sys_clk);
        set_addr(wr, a, sz);
        @(negedge sys_clk);
        clr_addr();
        hwdata = wd;
        rd = hrdata; r0 = hready_w; e0 = hresp;
        @(negedge sys_clk);
        r1 = hready_w; e1 = hresp;
        $display("xfer %s addr=%h size=%0d wdata=%h rdata=%h hready=%b%b hresp=%b%b",
                 wr ? "WR" : "RD", a, sz, wd, rd, r0, r1, e0, e1);
    endtask

    task automatic wr32(input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] rd;
        logic r0, e0, r1, e1;
        xfer(1'b1, a, 3'b010, wd, rd, r0, e0, r1, e1);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic r0, e0, r1, e1;
        xfer(1'b0, a, 3'b010, 32'd0, rd, r0, e0, r1, e1);
        chk(name, rd, exp);
    endtask

    // Data-phase schedule relative to the CTRL=5 write data cycle (k=0).
    function automatic op_t sched(input int k);
        op_t op;
        op.act = 1'b1; op.wr = 1'b0; op.addr = 32'h0C; op.wdata = 32'd0; op.exp = 32'd0;
        if (k >= 1 && k <= 9) begin
            op.addr = 32'h08;
            op.exp  = (k <= 5) ? 32'd1 : 32'd0;
        end else if (k == 10) op.exp = 32'd0;
        else if (k == 11) op.exp = 32'd1;
        else if (k == 13 || k == 20) begin
            op.wr = 1'b1; op.wdata = 32'd1;
        end else if (k == 15) op.exp = 32'd0;
        else if (k == 22) op.exp = 32'd1;
        else op.act = 1'b0;
        return op;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic r0, e0, r1, e1;
        op_t op, nxt;
        logic [31:0] a_exp [5];

        repeat (3) @(negedge sys_clk);
        chk("rst hready", {31'd0, hready_w}, 32'd1);
        chk("rst hresp", {31'd0, hresp}, 32'd0);
        chk("rst hrdata", hrdata, 32'd0);
        chk("rst irq", {31'd0, irq}, 32'd0);
        sys_rst = 1'b0;

        add(0, 32'h00, 3'd2, 32'h0, 32'h0, 0);
        add(0, 32'h04, 3'd2, 32'h0, 32'h0, 0);
        add(0, 32'h08, 3'd2, 32'h0, 32'h0, 0);
        add(0, 32'h0C, 3'd2, 32'h0, 32'h0, 0);
        add(0, 32'h10, 3'd2, 32'h0, 32'h0, 0);
        add(1, 32'h10, 3'd2, 32'hFFFF_1234, 32'h0, 0);
        add(0, 32'h10, 3'd2, 32'h0, 32'h0000_1234, 0);
        add(1, 32'h00, 3'd2, 32'hFFFF_FFFA, 32'h0, 0);
        add(0, 32'h00, 3'd2, 32'h0, 32'h2, 0);
        add(1, 32'h04, 3'd2, 32'h1234_5678, 32'h0, 0);
        add(0, 32'h04, 3'd2, 32'h0, 32'h1234_5678, 0);
        add(0, 32'h08, 3'd2, 32'h0, 32'h1234_5678, 0);
        add(1, 32'h00, 3'd0, 32'h0000_00FF, 32'h0, 1);
        add(0, 32'h00, 3'd2, 32'h0, 32'h2, 0);
        add(1, 32'h08, 3'd2, 32'h0, 32'h0, 1);
        add(0, 32'h08, 3'd2, 32'h0, 32'h1234_5678, 0);
        add(0, 32'h14, 3'd2, 32'h0, 32'h0, 1);
        add(0, 32'h1C, 3'd2, 32'h0, 32'h0, 1);
        add(0, 32'h04, 3'd1, 32'h0, 32'h0, 1);
        add(0, 32'hFFFF_FFE4, 3'd2, 32'h0, 32'h1234_5678, 0);
        add(1, 32'h0C, 3'd2, 32'h1, 32'h0, 0);
        add(0, 32'h0C, 3'd2, 32'h0, 32'h0, 0);
        add(1, 32'h00, 3'd2, 32'h0, 32'h0, 0);
        add(1, 32'h04, 3'd2, 32'h0, 32'h0, 0);
        add(1, 32'h10, 3'd2, 32'h0, 32'h0, 0);

        foreach (vecs[i]) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd, r0, e0, r1, e1);
            chk($sformatf("vec%0d hrdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d hready0", i), {31'd0, r0}, {31'd0, !vecs[i].exp_err});
            chk($sformatf("vec%0d hresp0", i), {31'd0, e0}, {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d hready1", i), {31'd0, r1}, 32'd1);
            chk($sformatf("vec%0d hresp1", i), {31'd0, e1}, {31'd0, vecs[i].exp_err});
        end

        // Free-running reload with PRESC=0: VALUE 3,2,1,0,3 on successive cycles.
        wr32(32'h04, 32'd3);
        a_exp = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
        @(negedge sys_clk); set_addr(1, 32'h00, 3'd2);
        @(negedge sys_clk); hwdata = 32'd7; set_addr(0, 32'h08, 3'd2);
        for (int k = 0; k < 5; k++) begin
            @(negedge sys_clk);
            chk($sformatf("reload value%0d", k), hrdata, a_exp[k]);
        end
        chk("reload irq before", {31'd0, irq}, 32'd0);
        @(negedge sys_clk);
        chk("reload value5", hrdata, 32'd2);
        chk("reload irq after", {31'd0, irq}, 32'd1);
        clr_addr();
        $display("seq reload done");

        // One-shot: EN self-clears, VALUE parks at 0, then clear IF and watch irq fall.
        wr32(32'h00, 32'd0);
        wr32(32'h0C, 32'd1);
        wr32(32'h04, 32'd2);
        wr32(32'h00, 32'd3);
        repeat (10) @(negedge sys_clk);
        rd_chk("oneshot ctrl", 32'h00, 32'd2);
        rd_chk("oneshot value", 32'h08, 32'd0);
        rd_chk("oneshot status", 32'h0C, 32'd1);
        chk("oneshot irq", {31'd0, irq}, 32'd1);
        @(negedge sys_clk); set_addr(1, 32'h0C, 3'd2);
        @(negedge sys_clk); hwdata = 32'd1; clr_addr();
        chk("clear irq data", {31'd0, irq}, 32'd1);
        @(negedge sys_clk);
        chk("clear irq +1", {31'd0, irq}, 32'd1);
        @(negedge sys_clk);
        chk("clear irq +2", {31'd0, irq}, 32'd0);
        rd_chk("clear status", 32'h0C, 32'd0);
        $display("seq oneshot done");

        // Prescale 4 with reload, plus a STATUS clear colliding with an underflow.
        wr32(32'h10, 32'd4);
        wr32(32'h04, 32'd1);
        @(negedge sys_clk); set_addr(1, 32'h00, 3'd2);
        @(negedge sys_clk); hwdata = 32'd5;
        nxt = sched(1);
        set_addr(nxt.wr, nxt.addr, 3'd2);
        for (int k = 1; k <= 22; k++) begin
            @(negedge sys_clk);
            op = sched(k);
            if (op.act && !op.wr) chk($sformatf("presc k%0d", k), hrdata, op.exp);
            if (op.act && op.wr) hwdata = op.wdata;
            nxt = sched(k + 1);
            if (nxt.act) set_addr(nxt.wr, nxt.addr, 3'd2);
            else clr_addr();
        end
        $display("seq prescale/collision done");

        // Back-to-back write then read of LOAD.
        wr32(32'h00, 32'd0);
        @(negedge sys_clk); set_addr(1, 32'h04, 3'd2);
        @(negedge sys_clk); hwdata = 32'hA5; set_addr(0, 32'h04, 3'd2);
        @(negedge sys_clk); clr_addr();
        chk("b2b read load", hrdata, 32'hA5);
        $display("seq back-to-back done");

        // Reset while the error response is in its first cycle.
        @(negedge sys_clk); set_addr(1, 32'h08, 3'd2);
        @(negedge sys_clk); clr_addr();
        chk("err1 hready", {31'd0, hready_w}, 32'd0);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("midrst hready", {31'd0, hready_w}, 32'd1);
        chk("midrst hresp", {31'd0, hresp}, 32'd0);
        chk("midrst hrdata", hrdata, 32'd0);
        chk("midrst irq", {31'd0, irq}, 32'd0);
        sys_rst = 1'b0;
        rd_chk("midrst load", 32'h04, 32'd0);
        rd_chk("midrst presc", 32'h10, 32'd0);
        $display("seq mid-transfer reset done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
